// File: rtl/cpuy_pkg.sv
// Shared types and constants for the instruction issuer: FSM states,
// length-decode codes, pointer width and the default HALT opcode.
package cpuy_pkg;

  localparam int PTR_W      = 8;
  localparam int CACHE_SIZE = 256;

  localparam logic [7:0] HALT_OPCODE_DEF = 8'hFF;

  localparam logic [1:0] LEN_1 = 2'd1;
  localparam logic [1:0] LEN_2 = 2'd2;
  localparam logic [1:0] LEN_3 = 2'd3;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  typedef logic [PTR_W-1:0] ptr_t;

endpackage

// File: rtl/instr_len_decode.sv
// Combinational instruction length decode from the top two opcode bits.
module instr_len_decode
  import cpuy_pkg::*;
(
  input  logic [1:0] len_sel,
  output logic [1:0] len
);

  always_comb begin
    len = LEN_1;
    unique case (len_sel)
      2'b00:   len = LEN_1;
      2'b01:   len = LEN_2;
      2'b10:   len = LEN_3;
      default: len = LEN_1;
    endcase
  end

endmodule

// File: rtl/instr_issuer.sv
// Issues complete instructions from the prefetch cache to the core and owns icp.
// Optional INSTR_ISSUER_STATS_EN adds saturating issued/stall counters.
//
// Handshake: an instruction transfers on a rising edge where instr_valid and
// instr_ready are both high; instr_valid never drops without a transfer unless
// an accepted redirect or reset discards the instruction, and the payload is
// held stable while instr_valid && !instr_ready.
module instr_issuer
  import cpuy_pkg::*;
#(
  parameter logic [7:0] HALT_OPCODE = HALT_OPCODE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] data_in_0,
  input  logic [7:0] data_in_1,
  input  logic [7:0] data_in_2,
  input  logic [7:0] ecp_value,
  output logic [7:0] icp_value,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [7:0] instr_opcode,
  output logic [7:0] instr_op1,
  output logic [7:0] instr_op2,
  output logic [1:0] instr_len,
  input  logic       redirect_valid,
  input  logic [7:0] redirect_addr,
  output logic       redirect_err,
  output logic       halted,
  output logic [1:0] dbg_state
`ifdef INSTR_ISSUER_STATS_EN
  ,
  output logic [15:0] issued_count,
  output logic [15:0] stall_count
`endif
);

  state_e     state_q, state_d;
  ptr_t       icp_q, icp_d;
  logic [7:0] opcode_q, opcode_d;
  logic [7:0] op1_q, op1_d;
  logic [7:0] op2_q, op2_d;
  logic [1:0] len_q, len_d;
  logic       err_q, err_d;

  logic [1:0] len_dec;
  ptr_t       avail;
  ptr_t       redir_dist;
  logic       redir_ok;
  logic       handshake;
  logic       bytes_ready;

  instr_len_decode u_len_decode (
    .len_sel (data_in_0[7:6]),
    .len     (len_dec)
  );

  // Both distances are mod-256; a target equal to ecp is still inside the window.
  assign avail       = ecp_value - icp_q;
  assign redir_dist  = redirect_addr - icp_q;
  assign redir_ok    = (redir_dist <= avail);
  assign handshake   = (state_q == ST_ISSUE) && instr_ready;
  assign bytes_ready = (avail >= {6'd0, len_dec});

  always_comb begin
    state_d  = state_q;
    icp_d    = icp_q;
    opcode_d = opcode_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    len_d    = len_q;
    err_d    = 1'b0;

    unique case (state_q)
      ST_WAIT: begin
        if (enable && bytes_ready) begin
          opcode_d = data_in_0;
          op1_d    = (len_dec >= LEN_2) ? data_in_1 : 8'd0;
          op2_d    = (len_dec == LEN_3) ? data_in_2 : 8'd0;
          len_d    = len_dec;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (instr_ready) begin
          icp_d   = icp_q + {6'd0, len_q};
          state_d = (opcode_q == HALT_OPCODE) ? ST_HALT : ST_WAIT;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: state_d = ST_WAIT;
    endcase

    // An accepted redirect overrides any advance; the window check uses the old icp.
    if (redirect_valid) begin
      if (redir_ok) begin
        icp_d   = redirect_addr;
        state_d = ST_WAIT;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_WAIT;
      icp_q    <= '0;
      opcode_q <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      len_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      icp_q    <= icp_d;
      opcode_q <= opcode_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      len_q    <= len_d;
      err_q    <= err_d;
    end
  end

  assign icp_value    = icp_q;
  assign instr_valid  = (state_q == ST_ISSUE);
  assign instr_opcode = opcode_q;
  assign instr_op1    = op1_q;
  assign instr_op2    = op2_q;
  assign instr_len    = len_q;
  assign redirect_err = err_q;
  assign halted       = (state_q == ST_HALT);
  assign dbg_state    = state_q;

`ifdef INSTR_ISSUER_STATS_EN
  logic [15:0] issued_q, issued_d;
  logic [15:0] stall_q, stall_d;
  logic        stall_now;

  assign stall_now = (state_q == ST_WAIT) && enable && !bytes_ready;

  always_comb begin
    issued_d = issued_q;
    stall_d  = stall_q;
    if (handshake && (issued_q != 16'hFFFF)) issued_d = issued_q + 16'd1;
    if (stall_now && (stall_q != 16'hFFFF))  stall_d  = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
    end
  end

  assign issued_count = issued_q;
  assign stall_count  = stall_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_instr_issuer.sv
// Directed bench for instr_issuer: a cache model feeds data_in_*, expected
// instructions go into a queue and a monitor pops them on each handshake.
module tb_instr_issuer;

  localparam int W = 26;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] data_in_0, data_in_1, data_in_2;
  logic [7:0] ecp_value;
  logic [7:0] icp_value;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr_opcode, instr_op1, instr_op2;
  logic [1:0] instr_len;
  logic       redirect_valid;
  logic [7:0] redirect_addr;
  logic       redirect_err;
  logic       halted;
  logic [1:0] dbg_state;
`ifdef INSTR_ISSUER_STATS_EN
  logic [15:0] issued_count;
  logic [15:0] stall_count;
  logic [15:0] sc0;
`endif

  logic [7:0] mem [256];
  logic [7:0] icp_p1, icp_p2;
  logic [W-1:0] exp_q[$];
  int n_checks;
  int n_fail;

  assign icp_p1    = icp_value + 8'd1;
  assign icp_p2    = icp_value + 8'd2;
  assign data_in_0 = mem[icp_value];
  assign data_in_1 = mem[icp_p1];
  assign data_in_2 = mem[icp_p2];

  instr_issuer dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .data_in_0      (data_in_0),
    .data_in_1      (data_in_1),
    .data_in_2      (data_in_2),
    .ecp_value      (ecp_value),
    .icp_value      (icp_value),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_opcode   (instr_opcode),
    .instr_op1      (instr_op1),
    .instr_op2      (instr_op2),
    .instr_len      (instr_len),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .redirect_err   (redirect_err),
    .halted         (halted),
    .dbg_state      (dbg_state)
`ifdef INSTR_ISSUER_STATS_EN
    ,
    .issued_count   (issued_count),
    .stall_count    (stall_count)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: one pop per handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst && instr_valid && instr_ready) begin
      logic [W-1:0] act;
      logic [W-1:0] exp_v;
      act = {instr_opcode, instr_op1, instr_op2, instr_len};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL issue_unexpected: got %h, none expected", act);
      end else begin
        exp_v = exp_q.pop_front();
        if (act !== exp_v) begin
          n_fail++;
          $display("FAIL issue_payload: got %h, expected %h", act, exp_v);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  task automatic push(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] len);
    exp_q.push_back({op, a, b, len});
  endtask

  task automatic wait_icp(input string name, input logic [7:0] target, input int budget);
    int k;
    k = 0;
    while ((icp_value !== target) && (k < budget)) begin
      tick();
      k++;
    end
    check(name, {24'd0, icp_value}, {24'd0, target});
  endtask

  task automatic redirect(input logic [7:0] addr);
    redirect_valid = 1'b1;
    redirect_addr  = addr;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst            = 1'b0;
    enable         = 1'b1;
    instr_ready    = 1'b1;
    ecp_value      = 8'd0;
    redirect_valid = 1'b0;
    redirect_addr  = 8'd0;

    // Reset and empty cache
    repeat (3) tick();
    check("reset_valid", {31'd0, instr_valid}, 32'd0);
    check("reset_len", {30'd0, instr_len}, 32'd0);
    rst = 1'b1;
    repeat (5) tick();
    check("empty_valid", {31'd0, instr_valid}, 32'd0);
    check("empty_icp", {24'd0, icp_value}, 32'd0);
    check("empty_halted", {31'd0, halted}, 32'd0);
    check("empty_err", {31'd0, redirect_err}, 32'd0);

    // Three-byte instruction
    mem[0] = 8'h81; mem[1] = 8'h12; mem[2] = 8'h34;
    push(8'h81, 8'h12, 8'h34, 2'd3);
    ecp_value = 8'd3;
    tick();
    check("len3_valid_latency", {31'd0, instr_valid}, 32'd1);
    wait_icp("len3_icp_advance", 8'd3, 10);

    // Pointer wrap: icp 254 -> 0 with a two-byte instruction
    enable    = 1'b0;
    ecp_value = 8'd1;
    redirect(8'd254);
    check("wrap_redirect_icp", {24'd0, icp_value}, 32'd254);
    mem[254] = 8'h40; mem[255] = 8'h56;
    push(8'h40, 8'h56, 8'h00, 2'd2);
    enable = 1'b1;
    wait_icp("wrap_icp", 8'd0, 10);

    // Insufficient bytes stall, then issue once ecp advances
    enable    = 1'b0;
    ecp_value = 8'd12;
    redirect(8'd10);
    check("stall_setup_icp", {24'd0, icp_value}, 32'd10);
    mem[10] = 8'h80; mem[11] = 8'hAB; mem[12] = 8'hCD;
`ifdef INSTR_ISSUER_STATS_EN
    sc0 = stall_count;
`endif
    enable = 1'b1;
    repeat (4) tick();
    check("stall_valid", {31'd0, instr_valid}, 32'd0);
    check("stall_icp", {24'd0, icp_value}, 32'd10);
`ifdef INSTR_ISSUER_STATS_EN
    check("stall_count", {16'd0, stall_count}, {16'd0, sc0 + 16'd4});
`endif
    instr_ready = 1'b0;
    ecp_value   = 8'd13;
    push(8'h80, 8'hAB, 8'hCD, 2'd3);
    tick();
    check("stall_release_valid", {31'd0, instr_valid}, 32'd1);
    repeat (2) tick();
    check("hold_valid", {31'd0, instr_valid}, 32'd1);
    check("hold_opcode", {24'd0, instr_opcode}, 32'h80);
    check("hold_op2", {24'd0, instr_op2}, 32'hCD);
    instr_ready = 1'b1;
    wait_icp("stall_icp_advance", 8'd13, 10);

    // Redirects with icp=10, ecp=20 (reach 10 through a 255-byte window)
    enable    = 1'b0;
    ecp_value = 8'd12;
    redirect(8'd10);
    check("redir_setup_icp", {24'd0, icp_value}, 32'd10);
    ecp_value   = 8'd20;
    instr_ready = 1'b0;
    enable      = 1'b1;
    tick();
    check("redir_pending_valid", {31'd0, instr_valid}, 32'd1);
    enable = 1'b0;
    tick();
    check("enable_low_keeps_valid", {31'd0, instr_valid}, 32'd1);
    redirect(8'd18);
    check("redir_accept_icp", {24'd0, icp_value}, 32'd18);
    check("redir_accept_drop", {31'd0, instr_valid}, 32'd0);
    check("redir_accept_err", {31'd0, redirect_err}, 32'd0);
    redirect(8'd5);
    check("redir_back_err", {31'd0, redirect_err}, 32'd1);
    check("redir_back_icp", {24'd0, icp_value}, 32'd18);
    tick();
    check("redir_err_pulse", {31'd0, redirect_err}, 32'd0);
    redirect(8'd21);
    check("redir_past_ecp_err", {31'd0, redirect_err}, 32'd1);
    redirect(8'd20);
    check("redir_to_ecp_icp", {24'd0, icp_value}, 32'd20);
    check("redir_to_ecp_err", {31'd0, redirect_err}, 32'd0);

    // Redirect in the same cycle as a handshake
    mem[20]   = 8'h01;
    ecp_value = 8'd30;
    push(8'h01, 8'h00, 8'h00, 2'd1);
    enable = 1'b1;
    tick();
    check("same_cycle_valid", {31'd0, instr_valid}, 32'd1);
    enable      = 1'b0;
    instr_ready = 1'b1;
    redirect(8'd25);
    check("same_cycle_icp", {24'd0, icp_value}, 32'd25);
    check("same_cycle_drop", {31'd0, instr_valid}, 32'd0);

    // HALT and resume by redirect
    mem[25] = 8'hFF;
    push(8'hFF, 8'h00, 8'h00, 2'd1);
    enable = 1'b1;
    wait_icp("halt_icp", 8'd26, 10);
    check("halt_halted", {31'd0, halted}, 32'd1);
    repeat (3) tick();
    check("halt_no_issue", {31'd0, instr_valid}, 32'd0);
    check("halt_icp_hold", {24'd0, icp_value}, 32'd26);
    mem[27] = 8'h42; mem[28] = 8'h99; mem[29] = 8'h05;
    push(8'h42, 8'h99, 8'h00, 2'd2);
    redirect(8'd27);
    check("resume_halted", {31'd0, halted}, 32'd0);
    check("resume_icp", {24'd0, icp_value}, 32'd27);
    wait_icp("resume_issue_icp", 8'd29, 10);
    instr_ready = 1'b0;
`ifdef INSTR_ISSUER_STATS_EN
    check("issued_count", {16'd0, issued_count}, 32'd6);
`endif

    // Reset asserted with an instruction pending
    tick();
    check("pre_reset_valid", {31'd0, instr_valid}, 32'd1);
    rst = 1'b0;
    #1;
    check("mid_reset_valid", {31'd0, instr_valid}, 32'd0);
    check("mid_reset_icp", {24'd0, icp_value}, 32'd0);
    check("mid_reset_opcode", {24'd0, instr_opcode}, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_issuer.md
# instr_issuer

Consumer side of the instruction prefetch cache. Owns the instruction cache pointer (`icp_value`) that the fetcher reads. Watches the three cache bytes at `icp_value` and the fetcher's write pointer (`ecp_value`), decodes the instruction length, and issues complete instructions to the CPU core over a valid/ready handshake. Supports forward redirects (taken branches) inside the prefetched window and a HALT opcode.

## Interface
- `CACHE_SIZE`, 256: cache depth; pointers are 8 bit and all pointer arithmetic is mod 256.
- `HALT_OPCODE`, 8'hFF: opcode that stops issuing after it has been delivered.
- `clk` in 1: clock; all state changes on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `enable` in 1: when low, no new instruction is captured; a pending instruction stays valid.
- `data_in_0/1/2` in 8 each: cache bytes at `icp`, `icp+1`, `icp+2` (combinational from the fetcher).
- `ecp_value` in 8: fetcher write pointer, i.e. next address to be filled.
- `icp_value` out 8: current issue pointer.
- `instr_valid` out 1: instruction registers hold a valid instruction.
- `instr_ready` in 1: CPU accepts the instruction.
- `instr_opcode`, `instr_op1`, `instr_op2` out 8 each: instruction bytes; unused operand bytes are 0.
- `instr_len` out 2: 1..3.
- `redirect_valid` in 1, `redirect_addr` in 8: branch target request.
- `redirect_err` out 1: one-cycle pulse when a redirect is rejected.
- `halted` out 1: high in HALT state.

## Operation
- `avail = (ecp_value - icp_value) mod 256`, 8-bit wrap subtraction. This is the number of bytes filled ahead of `icp`.
- Length decode on `data_in_0[7:6]`: 00→1, 01→2, 10→3, 11→1.
- FSM states:
  - WAIT: if `enable` and `avail >= len`, capture `data_in_0` into `instr_opcode`. Capture `data_in_1` and `data_in_2` into `instr_op1`/`instr_op2` only where `len` covers them, otherwise 0. Then go to ISSUE. Otherwise stay in WAIT.
  - ISSUE: `instr_valid` is high. On `instr_valid && instr_ready`: `icp <= icp + instr_len` (wraps). Then go to HALT if `instr_opcode == HALT_OPCODE`, otherwise to WAIT.
  - HALT: no issuing; left only by an accepted redirect.
- Redirect, evaluated in any state:
  - Accepted if `(redirect_addr - icp) mod 256 <= avail`, i.e. a forward skip within the filled window; equal to `icp` is allowed.
  - On accept: `icp <= redirect_addr`, next state WAIT, `instr_valid` drops and the pending instruction is discarded.
  - On reject: `redirect_err` pulses for one cycle and state and `icp` are unchanged.
- Redirect and handshake in the same cycle:
  - Redirect has priority and the window check uses the pre-advance `icp`.
  - The CPU has still consumed the instruction. `icp` takes the redirect target, not `icp + len`.
  - If the redirect is rejected, the handshake proceeds normally.
- `avail == 0` means the cache is empty, so the block waits. The fetcher guarantees `avail` never reaches 256.
- Reset (async assert, sync release): `icp_value=0`, `instr_valid=0`, `instr_opcode/op1/op2=0`, `instr_len=0`, `redirect_err=0`, `halted=0`, state WAIT. Asserting reset mid-instruction drops it immediately.

## Timing
- Capture is registered: `instr_valid` rises 1 cycle after WAIT sees sufficient bytes.
- The accept edge updates `icp`; fresh `data_in_*` are sampled the following cycle.
- Peak throughput is 1 instruction per 2 cycles.
- Outputs are stable while `instr_valid && !instr_ready`.
- `redirect_err` is registered and asserts the cycle after the request.
- `halted` is registered from the state.

## Configuration
- `INSTR_ISSUER_STATS_EN` defined: adds `issued_count` and `stall_count` outputs, 16 bits each, saturating at 16'hFFFF, reset to 0.
  - `issued_count` increments on each handshake.
  - `stall_count` increments each cycle in WAIT with `enable` high and `avail < len`.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

## Structure
- Shared package `cpuy_pkg`:
  - FSM state enum (WAIT, ISSUE, HALT).
  - Length-decode constants.
  - `HALT_OPCODE` default.
  - Pointer width `PTR_W=8`.
- One sub-module, `instr_len_decode`: combinational opcode → length (2 bit).

## Test plan
- Reset, `ecp=0` → `avail=0`; `instr_valid` stays 0 and `icp_value=0` indefinitely.
- `ecp=3`, bytes `0x81,0x12,0x34`, `instr_ready=1` → one cycle later: valid, opcode 0x81, op1 0x12, op2 0x34, len 3. After accept, `icp=3`.
- `icp=254`, `ecp=1`, opcode `0x40` (len 2) → issues (avail 3). After accept, `icp` wraps to 0.
- `icp=10`, `ecp=12`, opcode `0x80` (len 3) → stays in WAIT, `stall_count` increments. Raising `ecp` to 13 issues the instruction.
- Redirect tests with `icp=10`, `ecp=20`:
  - `redirect_addr=18` → accepted: `icp=18`, pending instruction dropped.
  - `redirect_addr=5` → `redirect_err` pulse, `icp=10`.
  - Redirect in the same cycle as a handshake → `icp` = target.
- Opcode `0xFF` issued and accepted → `icp+1`, `halted=1`, no further issue. An in-window redirect clears `halted` and resumes from WAIT.
